// File: rtl/mem_pkg.sv
// Shared packet-buffer memory parameters and arbiter types.
// Imported by the read- and write-side arbiters.
package mem_pkg;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned BLOCK_BITS = 64;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-set search: first asserted req at or after start, wrapping mod N.
// N need not be a power of two.
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] start,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int unsigned IdxW = $clog2(N);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    logic [IdxW-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = start;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
            cand = (cand == LastIdx) ? '0 : cand + IdxW'(1);
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter for the shared packet-buffer read port with optional burst lock,
// plus a fixed-latency tag pipeline that steers returned data to the issuing port.
module mem_read_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned READ_LAT  = 2,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N-1:0]               rd_req_i,
    input  logic [N-1:0][ADDR_W-1:0]   rd_addr_i,
    input  logic [N-1:0]               rd_lock_i,
    output logic [N-1:0]               rd_gnt_o,
    output logic [N-1:0]               rd_valid_o,
    output logic [BLOCK_BITS-1:0]      rd_data_o,
    output logic                       mem_re_o,
    output logic [ADDR_W-1:0]          mem_raddr_o,
    input  logic [BLOCK_BITS-1:0]      mem_rdata_i
);

    localparam int unsigned IdxW = $clog2(N);
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_BURST);
    localparam bit              LockEn  = (MAX_BURST > 1);

    typedef logic [IdxW-1:0] idx_t;

    function automatic idx_t inc_wrap(input idx_t i);
        return (i == LastIdx) ? '0 : i + idx_t'(1);
    endfunction

    arb_state_e      state_q, state_d;
    idx_t            ptr_q, ptr_d;
    idx_t            owner_q, owner_d;
    logic [CntW-1:0] burst_cnt_q, burst_cnt_d;

    logic pick_found;
    idx_t pick_idx;
    logic gnt_valid;
    idx_t gnt_idx;

    rr_pick #(
        .N(N)
    ) u_rr_pick (
        .req   (rd_req_i),
        .start (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Winner selection; everything is gated off while reset is asserted.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = pick_idx;
        unique case (state_q)
            ARB_IDLE: begin
                gnt_valid = pick_found;
                gnt_idx   = pick_idx;
            end
            ARB_LOCKED: begin
                gnt_valid = rd_req_i[owner_q];
                gnt_idx   = owner_q;
            end
        endcase
        if (!rst_n) begin
            gnt_valid = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (gnt_valid) begin
                    if (LockEn && rd_lock_i[gnt_idx]) begin
                        state_d     = ARB_LOCKED;
                        owner_d     = gnt_idx;
                        burst_cnt_d = CntW'(1);
                    end else begin
                        ptr_d = inc_wrap(gnt_idx);
                    end
                end
            end
            ARB_LOCKED: begin
                // Release on dropped request, dropped lock, or burst cap reached.
                if (!gnt_valid || !rd_lock_i[owner_q] ||
                    (burst_cnt_q + CntW'(1) == MaxCnt)) begin
                    state_d     = ARB_IDLE;
                    ptr_d       = inc_wrap(owner_q);
                    burst_cnt_d = '0;
                end else begin
                    burst_cnt_d = burst_cnt_q + CntW'(1);
                end
            end
        endcase
    end

    // Grant outputs
    always_comb begin
        rd_gnt_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            rd_gnt_o[i] = gnt_valid && (gnt_idx == idx_t'(i));
        end
        mem_re_o    = gnt_valid;
        mem_raddr_o = gnt_valid ? rd_addr_i[gnt_idx] : '0;
    end

    logic [READ_LAT-1:0] tag_vld_q;
    idx_t                tag_idx_q [READ_LAT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_vld_q <= '0;
        end else begin
            tag_vld_q[0] <= mem_re_o;
            for (int unsigned i = 1; i < READ_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_idx_q[0] <= gnt_idx;
        for (int unsigned i = 1; i < READ_LAT; i++) begin
            tag_idx_q[i] <= tag_idx_q[i-1];
        end
    end

    always_comb begin
        rd_valid_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            rd_valid_o[i] = rst_n && tag_vld_q[READ_LAT-1] &&
                            (tag_idx_q[READ_LAT-1] == idx_t'(i));
        end
    end

    assign rd_data_o = mem_rdata_i;

endmodule
